fm_exponent_pipe: RTL and testbench
===================================

// Module: fm_exponent_pipe
// PURPOSE
//  Parametrised, pipelined exponent datapath for the FP multiply/divide core.
//  - Forms the biased result exponent for multiply (ea+eb-BIAS) or divide (ea-eb+BIAS).
//  - Applies the mantissa range adjust and flags tiny/huge results.
//  - Computes the denormalisation right-shift amount.
//  - Keeps saturating tiny/huge event counters.
//  - Sits between operand prenormalisation and the round/pack stage; uses a valid/ready handshake.
// PARAMETERS
//  WEXP    8    exponent field width
//  WEXPSUM 10   internal two's-complement exponent width (WEXP+2)
//  BIAS    127  exponent bias
//  WMANT   23   stored mantissa width; sets the shift saturation limit
//  STAGES  2    pipeline register stages, legal 1..4
//  WCNT    16   event counter width
//  WSHAMT  5    shift width, $clog2(WMANT+3)
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        input operands valid
//  in_ready   out  1        block accepts input this cycle
//  op_div     in   1        0 = multiply, 1 = divide
//  expa       in   WEXPSUM  exponent A, two's complement (prenormalised denorms may be negative)
//  expb       in   WEXPSUM  exponent B, two's complement
//  adj        in   1        mul: product in [2,4) (+1); div: quotient < 1 (-1)
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  expsum     out  WEXPSUM  result exponent, two's complement
//  tiny       out  1        expsum <= 0 (signed): result is denormal or underflows
//  huge       out  1        expsum >= 2^WEXP-1 (signed): overflow
//  shamt      out  WSHAMT   denorm shift: tiny ? min(1-expsum, WMANT+2) : 0
//  tiny_cnt   out  WCNT     count of accepted tiny results, saturating
//  huge_cnt   out  WCNT     count of accepted huge results, saturating
//  cnt_clr    in   1        synchronous clear of both counters
// BEHAVIOUR
//  - Arithmetic is modulo 2^WEXPSUM. Operands are confined to ranges that cannot wrap.
//  - Computed combinationally at the input:
//    mul: s = expa + expb - BIAS + adj
//    div: s = expa - expb + BIAS - adj
//  - tiny, huge and shamt are computed from s at the input and carried with it.
//  - Pipeline: STAGES register slots, shifting in lockstep.
//    - en = ~out_valid | out_ready
//    - in_ready = en (combinational from out_valid and out_ready; no dependency on in_valid)
//    - When en: slot0 <= {in_valid, data}; slot k <= slot k-1.
//    - When ~en: all slots hold.
//    - Bubbles propagate as valid = 0. They are not squeezed out; this is a simple stall pipeline.
//  - Latency: STAGES cycles from input handshake to out_valid when there is no stall.
//    Throughput is 1 result per cycle.
//  - Outputs come from the last slot. Data holds stable while out_valid & ~out_ready.
//  - Ordering is preserved. No result is dropped or duplicated.
//  - Counters: on out_valid & out_ready, tiny_cnt += tiny and huge_cnt += huge.
//    - Each counter holds at 2^WCNT-1.
//    - cnt_clr has priority over a same-cycle increment; that event is lost.
//  - Reset:
//    - All slot valids = 0, so out_valid = 0.
//    - expsum = 0, tiny = 0, huge = 0, shamt = 0, tiny_cnt = 0, huge_cnt = 0.
//    - in_ready = 1 the cycle after reset.
//    - Reset mid-stream discards all in-flight results. No out_valid is asserted for them.
//  - in_valid while ~in_ready: no capture. The source holds its data.
//  - STAGES outside 1..4: elaboration error.
// TESTING (WEXP=8, BIAS=127, STAGES=2, WMANT=23)
//  1. Mul 130,127, adj=0, out_ready=1 -> 2 cycles later expsum=130, tiny=0, huge=0, shamt=0.
//  2. Mul 64,63, adj=0 -> expsum=0, tiny=1, shamt=1.
//     Mul 10,10, adj=0 -> expsum=-107 (0x395), tiny=1, shamt=25 (saturated).
//  3. Mul 200,182, adj=0 -> expsum=255, huge=1.
//     Mul 200,181, adj=1 -> expsum=255, huge=1.
//     Mul 200,181, adj=0 -> expsum=254, huge=0.
//  4. Div 127,130, adj=1 -> expsum=123.
//     Div 1,250, adj=0 -> expsum=-122, tiny=1, shamt=25.
//  5. Back-to-back mul inputs A,B,C; out_ready low for 3 cycles from A's arrival
//     -> in_ready drops; A,B,C emerge in order, each exactly once; data is stable while stalled.
//  6. Reset with 2 results in flight -> no out_valid for them; counters = 0.
//     Then WCNT=2 with 5 tiny results -> tiny_cnt=3.
//     cnt_clr concurrent with a tiny handshake -> tiny_cnt=0.

Source files
------------

// File: rtl/fm_exponent_pipe.sv
// Exponent datapath for the FP multiply/divide core: biased result exponent,
// tiny/huge flags, denorm shift amount, carried through a stall pipeline.
module fm_exponent_pipe #(
    parameter int WEXP    = 8,
    parameter int WEXPSUM = 10,
    parameter int BIAS    = 127,
    parameter int WMANT   = 23,
    parameter int STAGES  = 2,
    parameter int WCNT    = 16,
    parameter int WSHAMT  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_div,
    input  logic [WEXPSUM-1:0] expa,
    input  logic [WEXPSUM-1:0] expb,
    input  logic               adj,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WEXPSUM-1:0] expsum,
    output logic               tiny,
    output logic               huge,
    output logic [WSHAMT-1:0]  shamt,
    output logic [WCNT-1:0]    tiny_cnt,
    output logic [WCNT-1:0]    huge_cnt,
    input  logic               cnt_clr
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fm_exponent_pipe: STAGES must be in 1..4");
    end

    typedef struct packed {
        logic [WEXPSUM-1:0] s;
        logic               tiny;
        logic               huge;
        logic [WSHAMT-1:0]  shamt;
    } res_t;

    localparam logic [WEXPSUM-1:0] BIAS_W  = WEXPSUM'(BIAS);
    localparam logic [WEXPSUM-1:0] HUGE_TH = WEXPSUM'(2**WEXP - 1);
    localparam logic [WEXPSUM-1:0] SAT_W   = WEXPSUM'(WMANT + 2);
    localparam logic [WSHAMT-1:0]  SAT_SH  = WSHAMT'(WMANT + 2);

    res_t               res_d;
    logic [WEXPSUM-1:0] s;
    logic [WEXPSUM-1:0] adj_w;
    logic [WEXPSUM-1:0] one_m_s;

    always_comb begin
        res_d   = '0;
        adj_w   = WEXPSUM'(adj);
        s       = op_div ? (expa - expb + BIAS_W - adj_w)
                         : (expa + expb - BIAS_W + adj_w);
        one_m_s = WEXPSUM'(1) - s;
        res_d.s    = s;
        res_d.tiny = s[WEXPSUM-1] | (s == '0);
        res_d.huge = ~s[WEXPSUM-1] & (s >= HUGE_TH);
        // 1-s is positive whenever tiny, so an unsigned compare suffices
        if (res_d.tiny)
            res_d.shamt = (one_m_s > SAT_W) ? SAT_SH : one_m_s[WSHAMT-1:0];
    end

    logic [STAGES-1:0] vld_q;
    res_t [STAGES-1:0] dat_q;
    logic              en;

    assign out_valid = vld_q[STAGES-1];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= res_d;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign expsum = dat_q[STAGES-1].s;
    assign tiny   = dat_q[STAGES-1].tiny;
    assign huge   = dat_q[STAGES-1].huge;
    assign shamt  = dat_q[STAGES-1].shamt;

    logic [WCNT-1:0] tiny_cnt_q, tiny_cnt_d;
    logic [WCNT-1:0] huge_cnt_q, huge_cnt_d;
    logic            hs;

    assign hs = out_valid & out_ready;

    // A clear wins over a same-cycle event; that event is not counted
    always_comb begin
        tiny_cnt_d = tiny_cnt_q;
        huge_cnt_d = huge_cnt_q;
        if (cnt_clr) begin
            tiny_cnt_d = '0;
            huge_cnt_d = '0;
        end else if (hs) begin
            if (tiny && tiny_cnt_q != '1) tiny_cnt_d = tiny_cnt_q + 1'b1;
            if (huge && huge_cnt_q != '1) huge_cnt_d = huge_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tiny_cnt_q <= '0;
            huge_cnt_q <= '0;
        end else begin
            tiny_cnt_q <= tiny_cnt_d;
            huge_cnt_q <= huge_cnt_d;
        end
    end

    assign tiny_cnt = tiny_cnt_q;
    assign huge_cnt = huge_cnt_q;

endmodule

// File: tb/tb_fm_exponent_pipe.sv
// Scoreboard bench for fm_exponent_pipe: directed vectors with hand-computed
// results, a decoupled output monitor, stall/reset/counter scenarios.
module tb_fm_exponent_pipe;

    typedef struct packed {
        logic [9:0] s;
        logic       t;
        logic       h;
        logic [4:0] sh;
    } exp_t;

    logic       clk = 0;
    logic       reset = 1;
    logic       in_valid = 0, in_ready, op_div = 0, adj = 0;
    logic [9:0] expa = 0, expb = 0, expsum;
    logic       out_valid, out_ready = 1, tiny, huge, cnt_clr = 0;
    logic [4:0] shamt;
    logic [15:0] tiny_cnt, huge_cnt;

    logic       d2_in_valid = 0, d2_in_ready, d2_out_valid, d2_out_ready = 1;
    logic       d2_tiny, d2_huge, d2_cnt_clr = 0;
    logic [9:0] d2_expsum;
    logic [4:0] d2_shamt;
    logic [1:0] d2_tiny_cnt, d2_huge_cnt;

    always #5 clk = ~clk;

    fm_exponent_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_div(op_div), .expa(expa), .expb(expb), .adj(adj),
        .out_valid(out_valid), .out_ready(out_ready), .expsum(expsum),
        .tiny(tiny), .huge(huge), .shamt(shamt), .tiny_cnt(tiny_cnt),
        .huge_cnt(huge_cnt), .cnt_clr(cnt_clr)
    );

    fm_exponent_pipe #(.WCNT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .op_div(1'b0), .expa(10'd10), .expb(10'd10), .adj(1'b0),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .expsum(d2_expsum),
        .tiny(d2_tiny), .huge(d2_huge), .shamt(d2_shamt), .tiny_cnt(d2_tiny_cnt),
        .huge_cnt(d2_huge_cnt), .cnt_clr(d2_cnt_clr)
    );

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;   // stepped by the stimulus process
    int   m_chk = 0, m_fail = 0;   // stepped by the monitor
    int   n_out = 0, n_push = 0, exp_tiny = 0, exp_huge = 0;
    bit   hold_v = 0;
    exp_t hold_d;

    function automatic exp_t mk(logic [9:0] s, logic t, logic h, logic [4:0] sh);
        exp_t e;
        e.s = s; e.t = t; e.h = h; e.sh = sh;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t got, e;
        got = {expsum, tiny, huge, shamt};
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                m_chk++;
                if (out_valid !== 1'b1 || got !== hold_d) begin
                    m_fail++;
                    $display("FAIL stall_hold: got v=%b %h required v=1 %h", out_valid, got, hold_d);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = got;
            if (out_valid && out_ready) begin
                m_chk++;
                n_out++;
                if (sb.size() == 0) begin
                    m_fail++;
                    $display("FAIL unexpected_output: got %h required none", got);
                end else begin
                    e = sb.pop_front();
                    exp_tiny += int'(e.t);
                    exp_huge += int'(e.h);
                    if (got !== e) begin
                        m_fail++;
                        $display("FAIL result: got s=%h t=%b h=%b sh=%0d required s=%h t=%b h=%b sh=%0d",
                                 got.s, got.t, got.h, got.sh, e.s, e.t, e.h, e.sh);
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Called just after a posedge; returns just after the accepting edge
    task automatic send(logic op, logic [9:0] a, logic [9:0] b, logic ad, exp_t e, bit push);
        op_div = op; expa = a; expb = b; adj = ad; in_valid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                if (push) begin sb.push_back(e); n_push++; end
                #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int drops;
        bit seen;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {expsum, tiny, huge, shamt}, 0);
        chk("rst_counters", {tiny_cnt, huge_cnt}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // latency: accepted at an edge, visible after the second edge
        send(0, 10'd130, 10'd127, 0, mk(10'd130, 0, 0, 0), 1);
        idle();
        @(negedge clk); chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk); chk("lat_cycle2_valid", out_valid, 1);
        @(posedge clk); #1;

        send(0, 10'd64,  10'd63,  0, mk(10'd0,    1, 0, 5'd1),  1);
        send(0, 10'd10,  10'd10,  0, mk(10'h395,  1, 0, 5'd25), 1);
        send(0, 10'd200, 10'd182, 0, mk(10'd255,  0, 1, 0),     1);
        send(0, 10'd200, 10'd181, 1, mk(10'd255,  0, 1, 0),     1);
        send(0, 10'd200, 10'd181, 0, mk(10'd254,  0, 0, 0),     1);
        send(1, 10'd127, 10'd130, 1, mk(10'd123,  0, 0, 0),     1);
        send(1, 10'd1,   10'd250, 0, mk(10'd902,  1, 0, 5'd25), 1);
        send(0, 10'd52,  10'd52,  0, mk(10'h3E9,  1, 0, 5'd24), 1);
        send(0, 10'd52,  10'd51,  0, mk(10'h3E8,  1, 0, 5'd25), 1);
        send(0, 10'd64,  10'd64,  0, mk(10'd1,    0, 0, 0),     1);
        send(0, 10'h3FB, 10'd140, 0, mk(10'd8,    0, 0, 0),     1);
        idle();
        drain();

        // stall: out_ready low for 3 cycles from A's arrival
        drops = 0;
        seen = 0;
        fork
            begin
                send(0, 10'd100, 10'd100, 0, mk(10'd73,  0, 0, 0), 1);
                send(0, 10'd120, 10'd10,  0, mk(10'd3,   0, 0, 0), 1);
                send(0, 10'd150, 10'd150, 0, mk(10'd173, 0, 1'b0, 0), 1);
                idle();
            end
            begin
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk); #1;
                    seen = out_valid;
                end
                out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready) drops++;
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        chk("stall_seen_A", seen, 1);
        chk("stall_in_ready_low", drops, 3);
        drain();
        chk("order_count", n_out, n_push);
        chk("tiny_cnt", tiny_cnt, exp_tiny);
        chk("huge_cnt", huge_cnt, exp_huge);
        chk("tiny_cnt_value", tiny_cnt, 5);

        // reset with two results in flight, held back by a stalled consumer
        out_ready = 0;
        send(0, 10'd130, 10'd127, 0, mk(10'd130, 0, 0, 0), 0);
        send(0, 10'd10,  10'd10,  0, mk(10'h395, 1, 0, 5'd25), 0);
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        out_ready = 1;
        drops = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) drops++;
        end
        chk("flush_no_valid", drops, 0);
        chk("flush_counters", {tiny_cnt, huge_cnt}, 0);
        chk("flush_out_count", n_out, n_push);

        // narrow counter saturation and clear priority
        @(posedge clk); #1;
        d2_in_valid = 1;
        repeat (5) @(posedge clk);
        #1 d2_in_valid = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("d2_tiny_sat", d2_tiny_cnt, 3);
        chk("d2_huge_zero", d2_huge_cnt, 0);
        @(posedge clk); #1 d2_in_valid = 1;
        @(posedge clk); #1 d2_in_valid = 0;
        @(posedge clk); #1;
        chk("d2_clr_hs_valid", {d2_out_valid, d2_tiny}, 2'b11);
        d2_cnt_clr = 1;
        @(posedge clk); #1 d2_cnt_clr = 0;
        @(negedge clk);
        chk("d2_clr_priority", d2_tiny_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk + m_chk, n_fail + m_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
